// File: rtl/serial_frame_feeder_pkg.sv
// ============================================================================
// serial_stream_pkg : shared types and helpers for the serial stream feeder
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_stream_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP   = 2'd2
   } ser_state_t;

   localparam logic DEFAULT_IDLE_LEVEL = 1'b0;

   // Position of the bit sent on serial slot 'count' of a word.
   function automatic int unsigned bit_index(input int unsigned count,
                                             input int unsigned width,
                                             input bit          msb_first);
      return msb_first ? (width - 1 - count) : count;
   endfunction

endpackage

`default_nettype wire

// File: rtl/serial_frame_feeder_if.sv
// ============================================================================
// serial_frame_feeder_if : valid/ready word stream into the serial feeder
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

interface serial_frame_feeder_if #(
   parameter int WIDTH = 8
);
   logic             s_valid;
   logic             s_ready;
   logic [WIDTH-1:0] s_data;

   modport master (output s_valid, output s_data, input  s_ready);
   modport slave  (input  s_valid, input  s_data, output s_ready);
endinterface

`default_nettype wire

// File: rtl/serial_frame_feeder.sv
// ============================================================================
// serial_frame_feeder : serialises handshaked words into a 1-bit/clock stream
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_frame_feeder
   import serial_stream_pkg::*;
#(
   parameter int   WIDTH      = 8,
   parameter bit   MSB_FIRST  = 1'b1,
   parameter int   GAP_CYCLES = 0,
   parameter logic IDLE_LEVEL = DEFAULT_IDLE_LEVEL,
   parameter int   CNT_W      = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   serial_frame_feeder_if.slave s,
   output logic                 ser_out,
   output logic                 ser_active,
   output logic                 frame_start,
   output logic [CNT_W-1:0]     words_sent
);

   localparam int         CW       = $clog2(WIDTH);
   localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);
   localparam logic [7:0] GAP_LAST = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

   ser_state_t       r_state,     w_nxt_state;
   logic [CW-1:0]    r_bit_cnt,   w_nxt_cnt;
   logic [7:0]       r_gap_cnt,   w_nxt_gap;
   logic [WIDTH-1:0] r_word,      w_nxt_word;
   logic             r_hold_full, w_nxt_hold_full;
   logic [WIDTH-1:0] r_hold_data, w_nxt_hold_data;
   logic             w_accept, w_load_hold, w_load_in, w_done;
   logic [CW-1:0]    w_idx;
   logic             w_ser_out;

   assign s.s_ready = !r_hold_full;
   assign w_accept  = s.s_valid && !r_hold_full;

   always_comb begin
      w_nxt_state     = r_state;
      w_nxt_cnt       = r_bit_cnt;
      w_nxt_gap       = r_gap_cnt;
      w_nxt_word      = r_word;
      w_nxt_hold_full = r_hold_full;
      w_nxt_hold_data = r_hold_data;
      w_load_hold     = 1'b0;
      w_load_in       = 1'b0;
      w_done          = 1'b0;

      case (r_state)
         IDLE: begin
            if (r_hold_full)   w_load_hold = 1'b1;
            else if (w_accept) w_load_in   = 1'b1;
         end
         SHIFT: begin
            if (r_bit_cnt == BIT_LAST) begin
               w_done = 1'b1;
               if (GAP_CYCLES > 0) begin
                  w_nxt_state = GAP;
                  w_nxt_gap   = 8'd0;
               end else if (r_hold_full) begin
                  w_load_hold = 1'b1;
               end else if (w_accept) begin
                  w_load_in = 1'b1;
               end else begin
                  w_nxt_state = IDLE;
               end
            end else begin
               w_nxt_cnt = r_bit_cnt + CW'(1);
            end
         end
         GAP: begin
            if (r_gap_cnt == GAP_LAST) begin
               if (r_hold_full)   w_load_hold = 1'b1;
               else if (w_accept) w_load_in   = 1'b1;
               else               w_nxt_state = IDLE;
            end else begin
               w_nxt_gap = r_gap_cnt + 8'd1;
            end
         end
         default: w_nxt_state = IDLE;
      endcase

      if (w_load_hold || w_load_in) begin
         w_nxt_state = SHIFT;
         w_nxt_cnt   = '0;
         w_nxt_word  = w_load_hold ? r_hold_data : s.s_data;
      end
      if (w_load_hold) w_nxt_hold_full = 1'b0;
      // A handshake that did not go straight to the shifter parks in hold.
      if (w_accept && !w_load_in) begin
         w_nxt_hold_full = 1'b1;
         w_nxt_hold_data = s.s_data;
      end
   end

   // Outputs are registered copies of the next cycle's serial slot.
   assign w_idx     = CW'(bit_index(32'(w_nxt_cnt), WIDTH, MSB_FIRST));
   assign w_ser_out = (w_nxt_state == SHIFT) ? w_nxt_word[w_idx] : IDLE_LEVEL;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_bit_cnt   <= '0;
         r_gap_cnt   <= '0;
         r_word      <= '0;
         r_hold_full <= 1'b0;
         r_hold_data <= '0;
         ser_out     <= IDLE_LEVEL;
         ser_active  <= 1'b0;
         frame_start <= 1'b0;
         words_sent  <= '0;
      end else begin
         r_state     <= w_nxt_state;
         r_bit_cnt   <= w_nxt_cnt;
         r_gap_cnt   <= w_nxt_gap;
         r_word      <= w_nxt_word;
         r_hold_full <= w_nxt_hold_full;
         r_hold_data <= w_nxt_hold_data;
         ser_out     <= w_ser_out;
         ser_active  <= (w_nxt_state == SHIFT);
         frame_start <= w_load_hold || w_load_in;
         if (w_done) words_sent <= words_sent + CNT_W'(1);
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_serial_frame_feeder.sv
// ============================================================================
// tb_serial_frame_feeder : vector, corner-case and randomized model checks
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_frame_feeder;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   serial_frame_feeder_if #(.WIDTH(8)) if0 ();
   serial_frame_feeder_if #(.WIDTH(8)) if1 ();
   serial_frame_feeder_if #(.WIDTH(8)) if2 ();

   logic        so_a [3];
   logic        sa_a [3];
   logic        fs_a [3];
   logic [15:0] ws_a [3];

   // Instance 0: MSB first, no gap. 1: LSB first, no gap. 2: MSB first, gap 2.
   serial_frame_feeder #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP_CYCLES(0), .IDLE_LEVEL(1'b0), .CNT_W(16)) dut0 (
      .clk(clk), .rst_n(rst_n), .s(if0),
      .ser_out(so_a[0]), .ser_active(sa_a[0]), .frame_start(fs_a[0]), .words_sent(ws_a[0]));
   serial_frame_feeder #(.WIDTH(8), .MSB_FIRST(1'b0), .GAP_CYCLES(0), .IDLE_LEVEL(1'b0), .CNT_W(16)) dut1 (
      .clk(clk), .rst_n(rst_n), .s(if1),
      .ser_out(so_a[1]), .ser_active(sa_a[1]), .frame_start(fs_a[1]), .words_sent(ws_a[1]));
   serial_frame_feeder #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP_CYCLES(2), .IDLE_LEVEL(1'b0), .CNT_W(16)) dut2 (
      .clk(clk), .rst_n(rst_n), .s(if2),
      .ser_out(so_a[2]), .ser_active(sa_a[2]), .frame_start(fs_a[2]), .words_sent(ws_a[2]));

   bit msb_a [3] = '{1'b1, 1'b0, 1'b1};
   int gap_a [3] = '{0, 0, 2};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int inst, input logic v, input logic [7:0] d);
      case (inst)
         0:       begin if0.s_valid = v; if0.s_data = d; end
         1:       begin if1.s_valid = v; if1.s_data = d; end
         default: begin if2.s_valid = v; if2.s_data = d; end
      endcase
   endtask

   function automatic logic rdy(input int inst);
      case (inst)
         0:       return if0.s_ready;
         1:       return if1.s_ready;
         default: return if2.s_ready;
      endcase
   endfunction

   task automatic do_reset();
      for (int i = 0; i < 3; i++) drive(i, 1'b0, 8'h00);
      rst_n = 1'b0;
      #2;
      for (int i = 0; i < 3; i++) begin
         chk("rst_ser_out", 32'(so_a[i]), 32'd0);
         chk("rst_active",  32'(sa_a[i]), 32'd0);
         chk("rst_fstart",  32'(fs_a[i]), 32'd0);
         chk("rst_words",   32'(ws_a[i]), 32'd0);
         chk("rst_ready",   32'(rdy(i)),  32'd1);
      end
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();
   endtask

   typedef struct {
      int         inst;
      logic [7:0] word;
      logic [7:0] exp_seq;   // bit 7 is the first bit expected on the wire
   } vec_t;

   vec_t vecs [5];

   // Behavioural reference: word k accepted at edge E occupies cycles S..S+7,
   // S = max(E, previous S + 8 + gap); it waits in hold during cycles E..S-1.
   int         e_q [$];
   int         s_q [$];
   logic [7:0] w_q [$];

   task automatic random_run(input int inst, input int n, input int pct);
      int         last_s;
      logic       x_rdy, x_act, x_out, x_fs, v;
      int         x_ws, idx, st;
      logic [7:0] w, d;
      e_q.delete(); s_q.delete(); w_q.delete();
      last_s = -1000;
      do_reset();
      for (int t = 0; t < n; t++) begin
         x_rdy = 1'b1; x_act = 1'b0; x_out = 1'b0; x_fs = 1'b0; x_ws = 0;
         foreach (s_q[k]) begin
            if (e_q[k] <= t && t < s_q[k]) x_rdy = 1'b0;
            if (s_q[k] <= t && t < s_q[k] + 8) begin
               x_act = 1'b1;
               idx   = t - s_q[k];
               w     = w_q[k];
               x_out = msb_a[inst] ? w[7 - idx] : w[idx];
            end
            if (s_q[k] == t) x_fs = 1'b1;
            if (s_q[k] + 8 <= t) x_ws++;
         end
         chk("rnd_ready",  32'(rdy(inst)),   32'(x_rdy));
         chk("rnd_active", 32'(sa_a[inst]),  32'(x_act));
         chk("rnd_ser",    32'(so_a[inst]),  32'(x_out));
         chk("rnd_fstart", 32'(fs_a[inst]),  32'(x_fs));
         chk("rnd_words",  32'(ws_a[inst]),  32'(x_ws));
         v = ($urandom_range(0, 99) < pct);
         d = 8'($urandom);
         drive(inst, v, d);
         if (v && x_rdy) begin
            st = (t + 1 > last_s + 8 + gap_a[inst]) ? t + 1 : last_s + 8 + gap_a[inst];
            e_q.push_back(t + 1);
            s_q.push_back(st);
            w_q.push_back(d);
            last_s = st;
         end
         tick();
      end
      drive(inst, 1'b0, 8'h00);
   endtask

   initial begin
      logic [15:0] ws0;
      logic [18:0] stream, amask;

      vecs[0] = '{inst: 0, word: 8'hB4, exp_seq: 8'b10110100};
      vecs[1] = '{inst: 1, word: 8'hB4, exp_seq: 8'b00101101};
      vecs[2] = '{inst: 0, word: 8'hD8, exp_seq: 8'b11011000};
      vecs[3] = '{inst: 2, word: 8'h3C, exp_seq: 8'b00111100};
      vecs[4] = '{inst: 1, word: 8'h01, exp_seq: 8'b10000000};

      for (int i = 0; i < 3; i++) drive(i, 1'b0, 8'h00);
      #1;
      do_reset();

      // Single words from the vector table.
      foreach (vecs[i]) begin
         ws0 = ws_a[vecs[i].inst];
         drive(vecs[i].inst, 1'b1, vecs[i].word);
         tick();
         drive(vecs[i].inst, 1'b0, 8'h00);
         for (int b = 0; b < 8; b++) begin
            chk("vec_ser",    32'(so_a[vecs[i].inst]), 32'(vecs[i].exp_seq[7 - b]));
            chk("vec_active", 32'(sa_a[vecs[i].inst]), 32'd1);
            chk("vec_fstart", 32'(fs_a[vecs[i].inst]), (b == 0) ? 32'd1 : 32'd0);
            if (b < 7) tick();
         end
         tick();
         chk("vec_idle_ser",    32'(so_a[vecs[i].inst]), 32'd0);
         chk("vec_idle_active", 32'(sa_a[vecs[i].inst]), 32'd0);
         chk("vec_words",       32'(ws_a[vecs[i].inst]), 32'(ws0 + 16'd1));
         repeat (4) tick();
      end

      // Back-to-back FF then 00 with no gap: second word waits in hold.
      do_reset();
      drive(0, 1'b1, 8'hFF);
      tick();
      chk("b2b_ready0", 32'(rdy(0)), 32'd1);
      chk("b2b_ser0",   32'(so_a[0]), 32'd1);
      chk("b2b_fs0",    32'(fs_a[0]), 32'd1);
      drive(0, 1'b1, 8'h00);
      tick();
      drive(0, 1'b0, 8'h00);
      for (int c = 1; c < 16; c++) begin
         chk("b2b_active", 32'(sa_a[0]), 32'd1);
         chk("b2b_ser",    32'(so_a[0]), (c < 8) ? 32'd1 : 32'd0);
         chk("b2b_fstart", 32'(fs_a[0]), (c == 8) ? 32'd1 : 32'd0);
         chk("b2b_ready",  32'(rdy(0)),  (c >= 8) ? 32'd1 : 32'd0);
         tick();
      end
      chk("b2b_end_active", 32'(sa_a[0]), 32'd0);
      chk("b2b_words",      32'(ws_a[0]), 32'd2);

      // Two-cycle gap between AA and 55.
      do_reset();
      stream = {8'hAA, 2'b00, 8'h55, 1'b0};
      amask  = {8'hFF, 2'b00, 8'hFF, 1'b0};
      drive(2, 1'b1, 8'hAA);
      tick();
      chk("gap_ser",    32'(so_a[2]), 32'(stream[18]));
      chk("gap_fstart", 32'(fs_a[2]), 32'd1);
      drive(2, 1'b1, 8'h55);
      tick();
      drive(2, 1'b0, 8'h00);
      chk("gap_held_ready", 32'(rdy(2)), 32'd0);
      for (int c = 1; c < 19; c++) begin
         chk("gap_ser",    32'(so_a[2]), 32'(stream[18 - c]));
         chk("gap_active", 32'(sa_a[2]), 32'(amask[18 - c]));
         chk("gap_fstart", 32'(fs_a[2]), (c == 10) ? 32'd1 : 32'd0);
         tick();
      end
      chk("gap_words", 32'(ws_a[2]), 32'd2);

      // Reset mid-word with a word held: everything discarded.
      do_reset();
      drive(0, 1'b1, 8'h0F);
      tick();
      drive(0, 1'b0, 8'h00);
      repeat (8) tick();
      chk("mid_words_pre", 32'(ws_a[0]), 32'd1);
      drive(0, 1'b1, 8'hF0);
      tick();
      drive(0, 1'b1, 8'h33);
      tick();
      drive(0, 1'b0, 8'h00);
      tick();
      tick();
      chk("mid_active_pre", 32'(sa_a[0]), 32'd1);
      chk("mid_ready_pre",  32'(rdy(0)),  32'd0);
      rst_n = 1'b0;
      #1;
      chk("mid_ser",    32'(so_a[0]), 32'd0);
      chk("mid_active", 32'(sa_a[0]), 32'd0);
      chk("mid_ready",  32'(rdy(0)),  32'd1);
      chk("mid_words",  32'(ws_a[0]), 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int c = 0; c < 12; c++) begin
         tick();
         chk("post_rst_ser",    32'(so_a[0]), 32'd0);
         chk("post_rst_active", 32'(sa_a[0]), 32'd0);
      end

      // Randomized traffic against the reference model, all three configs.
      random_run(0, 300, 70);
      random_run(1, 300, 40);
      random_run(2, 300, 80);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
